// File: rtl/mem_port_arbiter_if.sv
// Load-issue, store-commit and d-cache request bundle of the memory port arbiter.
// master = core/cache side driving requests, slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int SB_DEPTH   = 4
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic                  ld_req_valid;
  logic [ADDR_WIDTH-1:0] ld_req_addr;
  logic [TAG_WIDTH-1:0]  ld_req_tag;
  logic                  ld_req_ready;

  logic                  st_commit_valid;
  logic [ADDR_WIDTH-1:0] st_commit_addr;
  logic [DATA_WIDTH-1:0] st_commit_data;
  logic                  st_commit_ready;

  logic                  flush;
  logic                  cache_stall;

  logic                  cache_valid;
  logic                  cache_write;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_data;
  logic [TAG_WIDTH-1:0]  cache_tag;

  logic                  sb_empty;
  logic [CNT_W-1:0]      sb_count;

  modport master (
    output ld_req_valid, ld_req_addr, ld_req_tag,
    output st_commit_valid, st_commit_addr, st_commit_data,
    output flush, cache_stall,
    input  ld_req_ready, st_commit_ready,
    input  cache_valid, cache_write, cache_addr, cache_data, cache_tag,
    input  sb_empty, sb_count
  );

  modport slave (
    input  ld_req_valid, ld_req_addr, ld_req_tag,
    input  st_commit_valid, st_commit_addr, st_commit_data,
    input  flush, cache_stall,
    output ld_req_ready, st_commit_ready,
    output cache_valid, cache_write, cache_addr, cache_data, cache_tag,
    output sb_empty, sb_count
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates loads vs buffered committed stores onto one d-cache port; request is registered (1 cycle).
// Backpressure: ld_req_ready only on a load grant, st_commit_ready = !full, cache_stall freezes everything.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int SB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] HALF = CW'(SB_DEPTH / 2);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef enum logic {NORMAL, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } sb_ent_t;

  sb_ent_t               sb_mem [SB_DEPTH];
  logic [PW:0]           wr_ptr, rd_ptr, scan_ptr;
  logic [CW-1:0]         sb_cnt, sb_cnt_nxt;
  state_t                state;
  logic [SW-1:0]         starve_cnt;
  logic                  live;
  logic                  full, empty, commit, conflict;
  logic                  ld_cand, st_cand, st_grant, ld_grant;

  logic                  cache_valid_q, cache_write_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic [DATA_WIDTH-1:0] cache_data_q;
  logic [TAG_WIDTH-1:0]  cache_tag_q;

  assign sb_cnt = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign commit = bus.st_commit_valid && !full;

  // A load may not overtake any older store to the same address, including one arriving now.
  always_comb begin
    conflict = bus.st_commit_valid && (bus.st_commit_addr == bus.ld_req_addr);
    scan_ptr = rd_ptr;
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_ptr = rd_ptr + CW'(i);
      if ((CW'(i) < sb_cnt) && (sb_mem[scan_ptr[PW-1:0]].addr == bus.ld_req_addr))
        conflict = 1'b1;
    end
  end

  assign ld_cand    = bus.ld_req_valid && !conflict && !bus.flush;
  assign st_cand    = !empty;
  assign st_grant   = live && !bus.cache_stall && st_cand &&
                      ((state == DRAIN) || (starve_cnt >= SLIM) || !ld_cand);
  assign ld_grant   = live && !bus.cache_stall && ld_cand && !st_grant;
  assign sb_cnt_nxt = sb_cnt + CW'(commit) - CW'(st_grant);

  always_ff @(posedge clk) begin
    if (commit)
      sb_mem[wr_ptr[PW-1:0]] <= '{addr: bus.st_commit_addr, data: bus.st_commit_data};
  end

  // live holds off grants for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      state         <= NORMAL;
      starve_cnt    <= '0;
      live          <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_write_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
      cache_tag_q   <= '0;
    end else begin
      live <= 1'b1;
      if (commit)
        wr_ptr <= wr_ptr + 1'b1;
      if (st_grant)
        rd_ptr <= rd_ptr + 1'b1;

      if (st_grant || empty)
        starve_cnt <= '0;
      else if (ld_grant && (starve_cnt < SLIM))
        starve_cnt <= starve_cnt + 1'b1;

      // Both directions judge occupancy after this cycle's commit/drain.
      case (state)
        NORMAL:  if (sb_cnt_nxt == CW'(SB_DEPTH)) state <= DRAIN;
        DRAIN:   if (sb_cnt_nxt <= HALF)          state <= NORMAL;
        default: state <= NORMAL;
      endcase

      if (!bus.cache_stall) begin
        if (st_grant) begin
          cache_valid_q <= 1'b1;
          cache_write_q <= 1'b1;
          cache_addr_q  <= sb_mem[rd_ptr[PW-1:0]].addr;
          cache_data_q  <= sb_mem[rd_ptr[PW-1:0]].data;
          cache_tag_q   <= '0;
        end else if (ld_grant) begin
          cache_valid_q <= 1'b1;
          cache_write_q <= 1'b0;
          cache_addr_q  <= bus.ld_req_addr;
          cache_data_q  <= '0;
          cache_tag_q   <= bus.ld_req_tag;
        end else begin
          cache_valid_q <= 1'b0;
          cache_write_q <= 1'b0;
          cache_addr_q  <= '0;
          cache_data_q  <= '0;
          cache_tag_q   <= '0;
        end
      end
    end
  end

  assign bus.ld_req_ready    = ld_grant;
  assign bus.st_commit_ready = !full;
  assign bus.cache_valid     = cache_valid_q;
  assign bus.cache_write     = cache_write_q;
  assign bus.cache_addr      = cache_addr_q;
  assign bus.cache_data      = cache_data_q;
  assign bus.cache_tag       = cache_tag_q;
  assign bus.sb_empty        = empty;
  assign bus.sb_count        = sb_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a random phase, every cycle compared against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TW = 6, SBD = 4, SLIM = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .SB_DEPTH(SBD)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .SB_DEPTH(SBD), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          sbq[$];
  bit            drain, live;
  int            starve;
  logic          e_valid, e_write;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [TW-1:0] e_tag;
  bit            m_commit, m_gst, m_gld, m_full;
  logic          obs_ld_rdy, obs_st_rdy;
  int            n_assert = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    drain   = 0;
    live    = 0;
    starve  = 0;
    e_valid = 0; e_write = 0; e_addr = '0; e_data = '0; e_tag = '0;
  endtask

  task automatic model_comb();
    bit conflict, ldc, stc;
    m_full   = (sbq.size() == SBD);
    m_commit = bus.st_commit_valid && !m_full;
    conflict = bus.st_commit_valid && (bus.st_commit_addr == bus.ld_req_addr);
    foreach (sbq[i]) if (sbq[i].a == bus.ld_req_addr) conflict = 1;
    ldc   = bus.ld_req_valid && !conflict && !bus.flush;
    stc   = (sbq.size() != 0);
    m_gst = live && !bus.cache_stall && stc && (drain || starve >= SLIM || !ldc);
    m_gld = live && !bus.cache_stall && !m_gst && ldc;
  endtask

  task automatic model_update();
    bit was_empty;
    ent_t e;
    was_empty = (sbq.size() == 0);
    if (!bus.cache_stall) begin
      if (m_gst) begin
        e_valid = 1; e_write = 1; e_addr = sbq[0].a; e_data = sbq[0].d; e_tag = '0;
      end else if (m_gld) begin
        e_valid = 1; e_write = 0; e_addr = bus.ld_req_addr; e_data = '0; e_tag = bus.ld_req_tag;
      end else begin
        e_valid = 0; e_write = 0; e_addr = '0; e_data = '0; e_tag = '0;
      end
    end
    if (m_gst) void'(sbq.pop_front());
    if (m_commit) begin
      e.a = bus.st_commit_addr;
      e.d = bus.st_commit_data;
      sbq.push_back(e);
    end
    if (m_gst || was_empty) starve = 0;
    else if (m_gld && starve < SLIM) starve++;
    if (!drain) drain = (sbq.size() == SBD);
    else        drain = !(sbq.size() <= SBD / 2);
    live = 1;
  endtask

  task automatic drive(input bit ldv, input logic [AW-1:0] lda, input logic [TW-1:0] ldt,
                       input bit stv, input logic [AW-1:0] sta, input logic [DW-1:0] std,
                       input bit fl, input bit stl);
    bus.ld_req_valid    = ldv;
    bus.ld_req_addr     = lda;
    bus.ld_req_tag      = ldt;
    bus.st_commit_valid = stv;
    bus.st_commit_addr  = sta;
    bus.st_commit_data  = std;
    bus.flush           = fl;
    bus.cache_stall     = stl;
  endtask

  // Entered just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    #1;
    model_comb();
    obs_ld_rdy = bus.ld_req_ready;
    obs_st_rdy = bus.st_commit_ready;
    chk("ld_req_ready",    32'(bus.ld_req_ready),    32'(m_gld));
    chk("st_commit_ready", 32'(bus.st_commit_ready), 32'(!m_full));
    chk("sb_count",        32'(bus.sb_count),        32'(sbq.size()));
    chk("sb_empty",        32'(bus.sb_empty),        32'(sbq.size() == 0));
    chk("cache_valid",     32'(bus.cache_valid),     32'(e_valid));
    chk("cache_write",     32'(bus.cache_write),     32'(e_write));
    chk("cache_addr",      bus.cache_addr,           e_addr);
    chk("cache_data",      bus.cache_data,           e_data);
    chk("cache_tag",       32'(bus.cache_tag),       32'(e_tag));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, '0, '0, 0, '0, '0, 0, 0);
    model_reset();
    @(negedge clk);
    chk("rst_valid", 32'(bus.cache_valid), 0);
    chk("rst_write", 32'(bus.cache_write), 0);
    chk("rst_addr",  bus.cache_addr, 0);
    chk("rst_data",  bus.cache_data, 0);
    chk("rst_tag",   32'(bus.cache_tag), 0);
    chk("rst_empty", 32'(bus.sb_empty), 1);
    chk("rst_count", 32'(bus.sb_count), 0);
    rst_n = 1'b1;

    // First cycle after release grants nothing; the same load goes next cycle.
    drive(1, 32'h100, TW'(5), 0, '0, '0, 0, 0);
    cycle();
    chk("first_cycle_no_grant", 32'(obs_ld_rdy), 0);
    cycle();
    chk("ld_same_cycle_ready", 32'(obs_ld_rdy), 1);
    drive(0, '0, '0, 0, '0, '0, 0, 0);
    chk("ld_out_valid", 32'(bus.cache_valid), 1);
    chk("ld_out_write", 32'(bus.cache_write), 0);
    chk("ld_out_addr",  bus.cache_addr, 32'h100);
    chk("ld_out_tag",   32'(bus.cache_tag), 5);

    // Load aliasing a store waits for the store to issue.
    drive(1, 32'h200, TW'(1), 1, 32'h200, 32'hDEAD, 0, 0);
    cycle();
    chk("alias_blk0", 32'(obs_ld_rdy), 0);
    drive(1, 32'h200, TW'(1), 0, '0, '0, 0, 0);
    cycle();
    chk("alias_blk1",   32'(obs_ld_rdy), 0);
    chk("alias_st_wr",  32'(bus.cache_write), 1);
    chk("alias_st_adr", bus.cache_addr, 32'h200);
    chk("alias_st_dat", bus.cache_data, 32'hDEAD);
    cycle();
    chk("alias_grant",  32'(obs_ld_rdy), 1);
    chk("alias_ld_adr", bus.cache_addr, 32'h200);
    chk("alias_ld_wr",  32'(bus.cache_write), 0);

    // Starvation: four load grants, then the pending store is forced.
    drive(0, '0, '0, 1, 32'h300, 32'hBEEF, 0, 0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h400 + 32'(4 * i), TW'(i), 0, '0, '0, 0, 0);
      cycle();
      chk("starve_ld_rdy", 32'(obs_ld_rdy), (i == 4) ? 0 : 1);
      if (i == 4) begin
        chk("starve_st_wr",  32'(bus.cache_write), 1);
        chk("starve_st_adr", bus.cache_addr, 32'h300);
      end
    end

    // Fill to full with loads winning, then DRAIN down to half.
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h2000 + 32'(4 * k), TW'(2), 1, 32'h1000 + 32'(4 * k), 32'hA000 + 32'(k), 0, 0);
      cycle();
      chk("fill_ld_rdy", 32'(obs_ld_rdy), 1);
    end
    chk("fill_count", 32'(bus.sb_count), 4);
    drive(1, 32'h2010, TW'(2), 1, 32'h1010, 32'hA004, 0, 0);
    cycle();
    chk("full_st_rdy",  32'(obs_st_rdy), 0);
    chk("drain_ld_blk", 32'(obs_ld_rdy), 0);
    drive(1, 32'h2010, TW'(2), 0, '0, '0, 0, 0);
    cycle();
    chk("drain_ld_blk2", 32'(obs_ld_rdy), 0);
    chk("drain_count",   32'(bus.sb_count), 2);
    cycle();
    chk("normal_ld_win", 32'(obs_ld_rdy), 1);

    // Flush blocks the load; store drains while a new one commits.
    drive(1, 32'h2014, TW'(3), 1, 32'h600, 32'h6, 1, 0);
    cycle();
    chk("flush_ld_rdy", 32'(obs_ld_rdy), 0);
    chk("flush_count",  32'(bus.sb_count), 2);
    chk("flush_st_adr", bus.cache_addr, 32'h1008);

    // Stall freezes outputs; load goes on the first unstalled cycle.
    for (int s = 0; s < 3; s++) begin
      drive(1, 32'h700, TW'(4), 0, '0, '0, 0, 1);
      cycle();
      chk("stall_ld_rdy", 32'(obs_ld_rdy), 0);
      chk("stall_addr",   bus.cache_addr, 32'h1008);
      chk("stall_write",  32'(bus.cache_write), 1);
    end
    drive(1, 32'h700, TW'(4), 0, '0, '0, 0, 0);
    cycle();
    chk("unstall_grant", 32'(obs_ld_rdy), 1);
    chk("unstall_addr",  bus.cache_addr, 32'h700);

    // Fill under stall to enter DRAIN, drain one, then reset mid-drain.
    drive(0, '0, '0, 1, 32'h800, 32'h1, 0, 1);
    cycle();
    drive(0, '0, '0, 1, 32'h804, 32'h2, 0, 1);
    cycle();
    chk("pre_rst_count", 32'(bus.sb_count), 4);
    drive(0, '0, '0, 0, '0, '0, 0, 0);
    cycle();
    chk("pre_rst_wr", 32'(bus.cache_write), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.cache_valid), 0);
    chk("mid_rst_write", 32'(bus.cache_write), 0);
    chk("mid_rst_addr",  bus.cache_addr, 0);
    chk("mid_rst_data",  bus.cache_data, 0);
    chk("mid_rst_count", 32'(bus.sb_count), 0);
    chk("mid_rst_empty", 32'(bus.sb_empty), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic over a small address space to provoke conflicts.
    for (int r = 0; r < 400; r++) begin
      drive($urandom_range(0, 99) < 70, 32'($urandom_range(0, 7)) << 2, TW'($urandom),
            $urandom_range(0, 99) < 45, 32'($urandom_range(0, 7)) << 2, 32'($urandom),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
